cpu_irq_ctrl: RTL and testbench



---
 rtl/cpu_irq_pkg.sv | 41 ++++
 rtl/irq_src_chan.sv | 61 ++++++
 rtl/cpu_irq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cpu_irq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_irq_pkg
// Description : Shared register offsets, CTRL bit positions and a priority
//               encoder helper for the 6502 interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_irq_pkg;

  // One byte of the CPU-visible register window
  typedef logic [7:0] reg_byte_t;

  // Register offsets from the window base
  localparam logic [2:0] OFS_STATUS = 3'd0;
  localparam logic [2:0] OFS_MASK   = 3'd1;
  localparam logic [2:0] OFS_MODE   = 3'd2;
  localparam logic [2:0] OFS_CTRL   = 3'd3;
  localparam logic [2:0] OFS_PRIO   = 3'd4;

  // Number of bytes decoded in the window
  localparam int WINDOW_BYTES = 5;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_NMI_EN = 1;

  // PRIO value returned when nothing is pending and unmasked
  localparam reg_byte_t PRIO_NONE = 8'hFF;

  // Index of the lowest set bit, PRIO_NONE if the vector is all zero
  function automatic reg_byte_t prio_enc(input reg_byte_t v);
    reg_byte_t idx;
    idx = PRIO_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = reg_byte_t'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_src_chan.sv
`default_nettype none
// ============================================================================
// Module      : irq_src_chan
// Description : One IRQ source channel: optional input synchronizer, rising
//               edge detector and pending flop (edge or level mode, set wins
//               over write-1-to-clear).
//               Optional macro CPU_IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_src_chan (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic clr,
  output logic pending
);

  logic src_s;
  logic src_q;
  logic rise;

`ifdef CPU_IRQ_CTRL_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-flop synchronizer for an asynchronous request line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  assign rise = src_s & ~src_q;

  // Edge history and pending state; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      src_q <= src_s;
      if (mode) begin
        pending <= rise | (pending & ~clr);
      end else begin
        pending <= src_s;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_irq_ctrl
// Description : Interrupt controller for the 6502 core. Merges NUM_SRC
//               request lines into an active-low IRQ with mask/mode/pending
//               registers, and stretches a dedicated NMI request into a
//               retriggerable active-low pulse. Registers sit at BASE_ADDR.
//               Optional macro CPU_IRQ_CTRL_SYNC_EN synchronizes src/nmi_src.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_irq_ctrl
  import cpu_irq_pkg::*;
#(
  parameter int                NUM_SRC   = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h4020,
  parameter int                NMI_PULSE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               nmi_src,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [7:0]         data_in,
  input  logic               wen,
  input  logic               ren,
  output logic [7:0]         data_out,
  output logic               irq,
  output logic               nmi
);

  localparam int               CNT_W      = $clog2(NMI_PULSE + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(NMI_PULSE);

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0] offset_full;
  logic [2:0]        offset;
  logic              in_win;
  logic              wr_hit;

  // Subtracting first makes the window test wrap-safe for any base
  assign offset_full = addr - BASE_ADDR;
  assign in_win      = offset_full < ADDR_W'(WINDOW_BYTES);
  assign offset      = offset_full[2:0];
  assign wr_hit      = wen & in_win;

  // --------------------------------------------------------- source state
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] clr;
  logic [1:0]         ctrl;

  assign clr = (wr_hit && offset == OFS_STATUS) ? data_in[NUM_SRC-1:0] : '0;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_src_chan u_chan (
        .clk     (clk),
        .rst     (rst),
        .src     (src[i]),
        .mode    (mode[i]),
        .clr     (clr[i]),
        .pending (pending[i])
      );
    end
  endgenerate

  // Bits 7:NUM_SRC of data_in have no destination in a narrow build
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  // Mask / mode / ctrl register writes; unimplemented bits are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      mode <= '0;
      ctrl <= '0;
    end else if (wr_hit) begin
      case (offset)
        OFS_MASK: mask <= data_in[NUM_SRC-1:0];
        OFS_MODE: mode <= data_in[NUM_SRC-1:0];
        OFS_CTRL: ctrl <= data_in[1:0];
        default:  ;
      endcase
    end
  end

  // ------------------------------------------------------ read path / PRIO
  reg_byte_t pend_b;
  reg_byte_t mask_b;
  reg_byte_t mode_b;
  reg_byte_t ctrl_b;
  reg_byte_t prio_b;
  reg_byte_t rd_val;

  // Zero-extend the NUM_SRC-wide registers to bus bytes and select read data
  always_comb begin
    pend_b                = '0;
    mask_b                = '0;
    mode_b                = '0;
    pend_b[NUM_SRC-1:0]   = pending;
    mask_b[NUM_SRC-1:0]   = mask;
    mode_b[NUM_SRC-1:0]   = mode;
    ctrl_b                = {6'b0, ctrl};
    prio_b                = prio_enc(pend_b & mask_b);
    rd_val                = 8'h00;
    if (in_win) begin
      case (offset)
        OFS_STATUS: rd_val = pend_b;
        OFS_MASK:   rd_val = mask_b;
        OFS_MODE:   rd_val = mode_b;
        OFS_CTRL:   rd_val = ctrl_b;
        OFS_PRIO:   rd_val = prio_b;
        default:    rd_val = 8'h00;
      endcase
    end
  end

  // Read data captured on ren and held until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (ren) begin
      data_out <= rd_val;
    end
  end

  // ------------------------------------------------------------------ IRQ
  // Registered active-low IRQ from enabled, unmasked pending sources
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b1;
    end else begin
      irq <= ~(ctrl[CTRL_IRQ_EN] & |(pending & mask));
    end
  end

  // ------------------------------------------------------------------ NMI
  logic nmi_s;
  logic nmi_q;
  logic nmi_trig;
  logic [CNT_W-1:0] nmi_cnt;
  logic [CNT_W-1:0] nmi_cnt_next;

`ifdef CPU_IRQ_CTRL_SYNC_EN
  logic nmi_sync1;
  logic nmi_sync2;

  // Two-flop synchronizer for the NMI request
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_sync1 <= 1'b0;
      nmi_sync2 <= 1'b0;
    end else begin
      nmi_sync1 <= nmi_src;
      nmi_sync2 <= nmi_sync1;
    end
  end

  assign nmi_s = nmi_sync2;
`else
  assign nmi_s = nmi_src;
`endif

  // Enable gates only the trigger, so an active pulse always runs to the end
  assign nmi_trig = nmi_s & ~nmi_q & ctrl[CTRL_NMI_EN];

  // Next pulse count: reload on trigger, otherwise count down to zero
  always_comb begin
    nmi_cnt_next = nmi_cnt;
    if (nmi_trig) begin
      nmi_cnt_next = PULSE_LOAD;
    end else if (nmi_cnt != '0) begin
      nmi_cnt_next = nmi_cnt - 1'b1;
    end
  end

  // Pulse counter, edge history and registered active-low NMI
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_q   <= 1'b0;
      nmi_cnt <= '0;
      nmi     <= 1'b1;
    end else begin
      nmi_q   <= nmi_s;
      nmi_cnt <= nmi_cnt_next;
      nmi     <= (nmi_cnt_next == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_irq_ctrl
// Description : Self-checking bench for cpu_irq_ctrl. Bus reads push their
//               expected byte to a scoreboard queue that a monitor pops when
//               data_out becomes valid; irq/nmi are checked directly.
//               Honors CPU_IRQ_CTRL_SYNC_EN for the extra input latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_irq_ctrl;

  localparam int          NUM_SRC   = 4;
  localparam int          ADDR_W    = 16;
  localparam logic [15:0] BASE      = 16'h4020;
  localparam int          NMI_PULSE = 2;
`ifdef CPU_IRQ_CTRL_SYNC_EN
  localparam int          SYNC_LAT  = 2;
`else
  localparam int          SYNC_LAT  = 0;
`endif

  localparam logic [2:0] O_STATUS = 3'd0;
  localparam logic [2:0] O_MASK   = 3'd1;
  localparam logic [2:0] O_MODE   = 3'd2;
  localparam logic [2:0] O_CTRL   = 3'd3;
  localparam logic [2:0] O_PRIO   = 3'd4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src;
  logic               nmi_src;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         data_in;
  logic               wen;
  logic               ren;
  logic [7:0]         data_out;
  logic               irq;
  logic               nmi;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic rd_seen = 1'b0;

  always #5 clk = ~clk;

  cpu_irq_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .NMI_PULSE (NMI_PULSE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .nmi_src  (nmi_src),
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .ren      (ren),
    .data_out (data_out),
    .irq      (irq),
    .nmi      (nmi)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // A read issued at an edge is compared on the following falling edge
  always @(posedge clk) rd_seen <= ren;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: read data %02h with no expected entry", data_out);
      end else begin
        check("read", data_out, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3 + SYNC_LAT) tick();
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [7:0] d);
    addr    = BASE + 16'(ofs);
    data_in = d;
    wen     = 1'b1;
    tick();
    wen     = 1'b0;
  endtask

  task automatic rd_addr(input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    ren  = 1'b1;
    sb.push_back(exp);
    tick();
    ren  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ofs, input logic [7:0] exp);
    rd_addr(BASE + 16'(ofs), exp);
  endtask

  task automatic wr_rd(input logic [2:0] ofs, input logic [7:0] d, input logic [7:0] exp);
    addr    = BASE + 16'(ofs);
    data_in = d;
    wen     = 1'b1;
    ren     = 1'b1;
    sb.push_back(exp);
    tick();
    wen     = 1'b0;
    ren     = 1'b0;
  endtask

  // Drive one or two nmi_src rises and measure low cycles and low runs
  task automatic nmi_run(input bit retrig, output int lows, output int runs);
    bit prev_low;
    prev_low = 1'b0;
    lows     = 0;
    runs     = 0;
    for (int c = 0; c < 16; c++) begin
      nmi_src = (c == 0) || (retrig && c == 2);
      tick();
      if (nmi == 1'b0) begin
        lows++;
        if (!prev_low) runs++;
        prev_low = 1'b1;
      end else begin
        prev_low = 1'b0;
      end
    end
    nmi_src = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int runs;

    rst     = 1'b1;
    src     = 4'hF;
    nmi_src = 1'b0;
    addr    = '0;
    data_in = '0;
    wen     = 1'b0;
    ren     = 1'b0;

    // Reset with all sources high
    repeat (3) tick();
    check("rst_irq", {7'b0, irq}, 8'h01);
    check("rst_nmi", {7'b0, nmi}, 8'h01);
    check("rst_data_out", data_out, 8'h00);
    rst = 1'b0;
    src = '0;
    tick();
    rd(O_STATUS, 8'h00);
    rd(O_MASK,   8'h00);
    rd(O_MODE,   8'h00);
    rd(O_CTRL,   8'h00);
    rd(O_PRIO,   8'hFF);
    rd_addr(BASE + 16'd5, 8'h00);
    rd_addr(BASE - 16'd1, 8'h00);
    rd_addr(16'h0000,     8'h00);
    wr(O_CTRL, 8'hFF);
    rd(O_CTRL, 8'h03);
    wr(O_MASK, 8'hFF);
    rd(O_MASK, 8'h0F);

    // Edge-mode IRQ on source 2
    wr(O_MODE, 8'h0F);
    wr(O_MASK, 8'h04);
    wr(O_CTRL, 8'h01);
    src = 4'b0100;
    for (int i = 1; i <= 2 + SYNC_LAT; i++) begin
      tick();
      if (i == 1) src = '0;
      check("irq_edge_lat", {7'b0, irq}, {7'b0, (i < 2 + SYNC_LAT)});
    end
    rd(O_STATUS, 8'h04);
    rd(O_PRIO,   8'h02);
    wr(O_STATUS, 8'h04);
    check("irq_w1c_same", {7'b0, irq}, 8'h00);
    tick();
    check("irq_w1c_next", {7'b0, irq}, 8'h01);
    rd(O_STATUS, 8'h00);

    // Simultaneous write and read returns the pre-write value
    wr_rd(O_MASK, 8'h01, 8'h04);
    rd(O_MASK, 8'h01);

    // Level-mode IRQ on sources 0 and 1
    wr(O_MODE, 8'h00);
    wr(O_MASK, 8'h03);
    src = 4'b0011;
    settle();
    rd(O_PRIO, 8'h00);
    check("irq_level", {7'b0, irq}, 8'h00);
    wr(O_STATUS, 8'h01);
    settle();
    rd(O_STATUS, 8'h03);
    src = 4'b0010;
    settle();
    rd(O_STATUS, 8'h02);
    rd(O_PRIO,   8'h01);
    src = '0;
    settle();
    rd(O_STATUS, 8'h00);
    check("irq_level_drop", {7'b0, irq}, 8'h01);

    // Edge set colliding with W1C on source 1: set wins
    wr(O_MODE, 8'h0F);
    wr(O_MASK, 8'h02);
    settle();
    src = 4'b0010;
    repeat (SYNC_LAT) tick();
    wr(O_STATUS, 8'h02);
    tick();
    check("irq_collision", {7'b0, irq}, 8'h00);
    rd(O_STATUS, 8'h02);
    wr(O_CTRL, 8'h00);
    check("irq_disable_same", {7'b0, irq}, 8'h00);
    tick();
    check("irq_disable_next", {7'b0, irq}, 8'h01);
    src = '0;
    wr(O_STATUS, 8'h0F);
    rd(O_STATUS, 8'h00);

    // NMI: single pulse, retrigger, disabled
    wr(O_CTRL, 8'h02);
    nmi_run(1'b0, lows, runs);
    check("nmi_single_lows", 8'(lows), 8'(NMI_PULSE));
    check("nmi_single_runs", 8'(runs), 8'd1);
    nmi_run(1'b1, lows, runs);
    check("nmi_retrig_lows", 8'(lows), 8'(2 + NMI_PULSE));
    check("nmi_retrig_runs", 8'(runs), 8'd1);
    wr(O_CTRL, 8'h00);
    nmi_run(1'b0, lows, runs);
    check("nmi_disabled_lows", 8'(lows), 8'd0);

    // Reset during an active NMI pulse
    wr(O_CTRL, 8'h02);
    nmi_src = 1'b1;
    repeat (1 + SYNC_LAT) tick();
    nmi_src = 1'b0;
    check("nmi_pulse_active", {7'b0, nmi}, 8'h00);
    rst = 1'b1;
    tick();
    check("rst_mid_nmi", {7'b0, nmi}, 8'h01);
    check("rst_mid_irq", {7'b0, irq}, 8'h01);
    check("rst_mid_data_out", data_out, 8'h00);
    rst = 1'b0;
    tick();
    rd(O_CTRL, 8'h00);
    repeat (3) tick();
    check("nmi_after_rst", {7'b0, nmi}, 8'h01);

    repeat (2) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d expected reads never observed, need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
